// File: rtl/stereo_pkg.sv
// Shared constants, state type and pixel helper for the stereo matching pipeline
// (row fetcher and SAD disparity search).
package stereo_pkg;

  localparam int BLOCK_SIZE    = 6;
  localparam int PIX_W         = 6;
  localparam int PIX_PER_WORD  = 8;
  localparam int WORDS_PER_ROW = 40;

  localparam int WORD_W  = PIX_W * PIX_PER_WORD;
  localparam int WIN_PIX = 2 * PIX_PER_WORD;
  localparam int WIN_W   = PIX_W * WIN_PIX;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  // A window is {front, back}, so pixel k sits at bits [6k+5:6k].
  function automatic logic [PIX_W-1:0] get_pixel(input logic [WIN_W-1:0] win,
                                                 input logic [3:0]       idx);
    return win[int'(idx)*PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/sad_row.sv
// Combinational single-row SAD: left pixels 0..5 against right pixels d..d+5
// of two 16-pixel windows.
module sad_row
  import stereo_pkg::*;
(
  input  logic [WIN_W-1:0] lwin_i,
  input  logic [WIN_W-1:0] rwin_i,
  input  logic [3:0]       d_i,
  output logic [8:0]       sad_o
);

  logic [PIX_W-1:0] lp;
  logic [PIX_W-1:0] rp;
  logic [PIX_W-1:0] diff;
  logic [8:0]       sum;

  always_comb begin
    lp   = '0;
    rp   = '0;
    diff = '0;
    sum  = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      lp   = get_pixel(lwin_i, 4'(i));
      rp   = get_pixel(rwin_i, d_i + 4'(i));
      diff = (lp > rp) ? (lp - rp) : (rp - lp);
      sum  = sum + 9'(diff);
    end
  end

  assign sad_o = sum;

endmodule

// File: rtl/sad_disparity_search.sv
// Block-matching cost stage: snapshots the four row buffers, accumulates a 6x6
// SAD for each disparity one row per cycle, and reports the cheapest disparity.
module sad_disparity_search
  import stereo_pkg::*;
#(
  parameter int MAX_DISP = 10,
  parameter int COST_W   = 12
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic                                   valid_in,
  input  logic [BLOCK_SIZE-1:0][WORD_W-1:0]      left_front_buffer,
  input  logic [BLOCK_SIZE-1:0][WORD_W-1:0]      left_back_buffer,
  input  logic [BLOCK_SIZE-1:0][WORD_W-1:0]      right_front_buffer,
  input  logic [BLOCK_SIZE-1:0][WORD_W-1:0]      right_back_buffer,
  output logic                                   ready_out,
  output logic [3:0]                             disparity_out,
  output logic [COST_W-1:0]                      cost_out,
  output logic                                   valid_out
);

  state_e                             state_q;
  logic [BLOCK_SIZE-1:0][WORD_W-1:0]  lf_q, lb_q, rf_q, rb_q;
  logic [2:0]                         r_q;
  logic [3:0]                         d_q;
  logic [COST_W-1:0]                  acc_q;
  logic [COST_W-1:0]                  best_cost_q;
  logic [3:0]                         best_disp_q;
  logic [3:0]                         disp_q;
  logic [COST_W-1:0]                  cost_q;
  logic                               valid_q;

  logic [WIN_W-1:0]  lwin, rwin;
  logic [8:0]        row_sad;
  logic [COST_W-1:0] acc_d;
  logic              take_best;
  logic [COST_W-1:0] best_cost_d;
  logic [3:0]        best_disp_d;

  assign lwin = {lf_q[r_q], lb_q[r_q]};
  assign rwin = {rf_q[r_q], rb_q[r_q]};

  sad_row u_sad_row (
    .lwin_i (lwin),
    .rwin_i (rwin),
    .d_i    (d_q),
    .sad_o  (row_sad)
  );

  // d=0 always seeds the best; later disparities must be strictly cheaper so ties keep the lowest d.
  assign acc_d       = acc_q + COST_W'(row_sad);
  assign take_best   = (d_q == 4'd0) || (acc_d < best_cost_q);
  assign best_cost_d = take_best ? acc_d : best_cost_q;
  assign best_disp_d = take_best ? d_q   : best_disp_q;

  assign ready_out     = (state_q == IDLE);
  assign disparity_out = disp_q;
  assign cost_out      = cost_q;
  assign valid_out     = valid_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      lf_q        <= '0;
      lb_q        <= '0;
      rf_q        <= '0;
      rb_q        <= '0;
      r_q         <= '0;
      d_q         <= '0;
      acc_q       <= '0;
      best_cost_q <= '0;
      best_disp_q <= '0;
      disp_q      <= '0;
      cost_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            lf_q    <= left_front_buffer;
            lb_q    <= left_back_buffer;
            rf_q    <= right_front_buffer;
            rb_q    <= right_back_buffer;
            r_q     <= '0;
            d_q     <= '0;
            acc_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (r_q == 3'(BLOCK_SIZE - 1)) begin
            acc_q       <= '0;
            r_q         <= '0;
            d_q         <= d_q + 4'd1;
            best_cost_q <= best_cost_d;
            best_disp_q <= best_disp_d;
            if (d_q == 4'(MAX_DISP)) begin
              disp_q  <= best_disp_d;
              cost_q  <= best_cost_d;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            acc_q <= acc_d;
            r_q   <= r_q + 3'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sad_disparity_search.sv
// Randomized scoreboard bench for sad_disparity_search: a plain-arithmetic
// disparity search model feeds an expectation queue drained by a monitor.
module tb_sad_disparity_search;

  localparam int LAT = 67;

  logic                 clk_in = 1'b0;
  logic                 rst_in = 1'b0;
  logic                 valid_in = 1'b0;
  logic [5:0][47:0]     left_front_buffer  = '0;
  logic [5:0][47:0]     left_back_buffer   = '0;
  logic [5:0][47:0]     right_front_buffer = '0;
  logic [5:0][47:0]     right_back_buffer  = '0;
  logic                 ready_out;
  logic [3:0]           disparity_out;
  logic [11:0]          cost_out;
  logic                 valid_out;

  sad_disparity_search #(.MAX_DISP(10), .COST_W(12)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .valid_in           (valid_in),
    .left_front_buffer  (left_front_buffer),
    .left_back_buffer   (left_back_buffer),
    .right_front_buffer (right_front_buffer),
    .right_back_buffer  (right_back_buffer),
    .ready_out          (ready_out),
    .disparity_out      (disparity_out),
    .cost_out           (cost_out),
    .valid_out          (valid_out)
  );

  always #5 clk_in = ~clk_in;

  longint cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int     disp;
    int     cost;
    longint when;
  } exp_t;

  exp_t sbq[$];
  int   compared   = 0;
  int   mismatched = 0;

  int lpix[6][16];
  int rpix[6][16];

  task automatic checkOutput(input string name, input longint act, input longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Behavioural reference: exhaustive search over all disparities, lowest d wins ties.
  task automatic refModel(output int bd, output int bc);
    bd = 0;
    bc = 0;
    for (int d = 0; d <= 10; d++) begin
      int c;
      c = 0;
      for (int r = 0; r < 6; r++)
        for (int k = 0; k < 6; k++)
          c += (lpix[r][k] > rpix[r][k+d]) ? lpix[r][k] - rpix[r][k+d] : rpix[r][k+d] - lpix[r][k];
      if (d == 0 || c < bc) begin
        bd = d;
        bc = c;
      end
    end
  endtask

  task automatic packAll();
    for (int r = 0; r < 6; r++)
      for (int k = 0; k < 8; k++) begin
        left_back_buffer[r][k*6 +: 6]   = 6'(lpix[r][k]);
        left_front_buffer[r][k*6 +: 6]  = 6'(lpix[r][k+8]);
        right_back_buffer[r][k*6 +: 6]  = 6'(rpix[r][k]);
        right_front_buffer[r][k*6 +: 6] = 6'(rpix[r][k+8]);
      end
  endtask

  task automatic randImages();
    for (int r = 0; r < 6; r++)
      for (int k = 0; k < 16; k++) begin
        lpix[r][k] = int'($urandom_range(63));
        rpix[r][k] = int'($urandom_range(63));
      end
  endtask

  // Right row r is left row r shifted right by s pixels; the remaining pixels stay random.
  task automatic shiftedImages(input int s);
    randImages();
    for (int r = 0; r < 6; r++)
      for (int k = 0; k + s < 16; k++)
        rpix[r][k+s] = lpix[r][k];
  endtask

  task automatic applyStimulus(output longint c0);
    int ed, ec;
    checkOutput("ready_at_issue", longint'(ready_out), 1);
    refModel(ed, ec);
    packAll();
    c0 = cyc;
    sbq.push_back('{ed, ec, c0 + LAT});
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic waitDone();
    for (int i = 0; i < 300 && sbq.size() != 0; i++) tick();
    if (sbq.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL result_timeout: got %0d pending results, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_ready"}, longint'(ready_out), 1);
    checkOutput({tag, "_valid"}, longint'(valid_out), 0);
    checkOutput({tag, "_disp"},  longint'(disparity_out), 0);
    checkOutput({tag, "_cost"},  longint'(cost_out), 0);
  endtask

  // Monitor: every valid_out must match the oldest outstanding expectation, in value and cycle.
  always @(negedge clk_in) begin
    if (rst_in && valid_out) begin
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_valid: got valid_out at cycle %0d, required none", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput("disparity", longint'(disparity_out), e.disp);
        checkOutput("cost", longint'(cost_out), e.cost);
        checkOutput("latency_cycle", cyc, e.when);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no end of test, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint c0, c1;
    repeat (3) tick();
    checkIdleZero("reset");
    rst_in = 1'b1;
    tick();
    checkIdleZero("post_reset");

    $display("[TB] identical images");
    randImages();
    rpix = lpix;
    applyStimulus(c0);
    waitDone();

    $display("[TB] shift by 3");
    shiftedImages(3);
    applyStimulus(c0);
    waitDone();

    $display("[TB] saturated tie");
    for (int r = 0; r < 6; r++)
      for (int k = 0; k < 16; k++) begin
        lpix[r][k] = 63;
        rpix[r][k] = 0;
      end
    applyStimulus(c0);
    waitDone();

    $display("[TB] match only at d=10, inputs scrambled during run");
    shiftedImages(10);
    for (int r = 0; r < 6; r++)
      for (int k = 0; k < 10; k++)
        rpix[r][k] = lpix[r][k] ^ 32;
    applyStimulus(c0);
    repeat (10) tick();
    randImages();
    packAll();
    waitDone();

    $display("[TB] ignored pulses and back-to-back");
    randImages();
    applyStimulus(c0);
    while (cyc < c0 + 5) tick();
    checkOutput("busy_ready_c5", longint'(ready_out), 0);
    randImages();
    packAll();
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    while (cyc < c0 + 40) tick();
    checkOutput("busy_ready_c40", longint'(ready_out), 0);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    while (cyc < c0 + LAT) tick();
    shiftedImages(int'($urandom_range(10)));
    applyStimulus(c1);
    checkOutput("back_to_back_issue", c1, c0 + LAT);
    waitDone();

    $display("[TB] reset mid-run");
    randImages();
    applyStimulus(c0);
    while (cyc < c0 + 30) tick();
    rst_in = 1'b0;
    sbq.delete();
    #1;
    checkIdleZero("mid_reset");
    tick();
    tick();
    rst_in = 1'b1;
    tick();
    checkIdleZero("after_abort");
    shiftedImages(7);
    applyStimulus(c0);
    waitDone();

    $display("[TB] random sweep");
    for (int t = 0; t < 8; t++) begin
      if (t % 2 == 0) randImages();
      else shiftedImages(int'($urandom_range(10)));
      applyStimulus(c0);
      waitDone();
    end

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sad_disparity_search.md
# sad_disparity_search

Block-matching cost stage directly downstream of the four-buffer row fetcher. When the fetcher signals a fresh set of six-row left/right front/back buffers, this block snapshots them and searches right-image disparities 0..MAX_DISP. Each disparity is scored by a 6x6 sum of absolute differences (SAD). The block reports the best disparity and its cost to the depth-map writer.

## Interface
Parameters:
- BLOCK_SIZE, 6, rows and columns of the matching block
- PIX_W, 6, bits per pixel
- PIX_PER_WORD, 8, pixels per 48-bit buffer word
- MAX_DISP, 10, largest disparity searched; must be ≤ 2*PIX_PER_WORD − BLOCK_SIZE
- COST_W, 12, cost width = clog2(BLOCK_SIZE²·(2^PIX_W−1)+1)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- valid_in  input  1  one-cycle pulse: all four buffers are valid
- left_front_buffer  input  [5:0][47:0]  row r = left word word_idx+1 of row y+r
- left_back_buffer  input  [5:0][47:0]  row r = left word word_idx of row y+r
- right_front_buffer  input  [5:0][47:0]  same, right image
- right_back_buffer  input  [5:0][47:0]  same, right image
- ready_out  output  1  high when idle; valid_in accepted only while high
- disparity_out  output  [3:0]  winning disparity
- cost_out  output  [COST_W-1:0]  SAD of winning disparity
- valid_out  output  1  one-cycle pulse: disparity_out/cost_out updated

## Operation
- Window per row r is 16 pixels: {front[r], back[r]}. Pixel k occupies bits [6k+5:6k]. Pixels 0–7 come from back; 8–15 come from front.
- Left block: pixels 0..5 of left rows 0..5.
- Right block at disparity d: pixels d..d+5 of right rows 0..5.
- States:
  - IDLE: ready_out=1. On valid_in, copy all four buffers into snapshot registers; clear d, r and acc; go to RUN. Later changes to the input buffers must not affect the result.
  - RUN: one row per cycle. acc_next = acc + rowsad(r,d), where rowsad is the sum of 6 unsigned |L−R|.
    - When r=5, compare acc_next against best_cost. Update best if strictly less, or if d=0. Then clear acc, set r=0, and increment d.
    - When r=5 and d=MAX_DISP, register the final best into disparity_out/cost_out, pulse valid_out, and go to IDLE.
- Tie rule: the lowest disparity wins (strict < comparison).
- valid_in while ready_out=0 is ignored; it is not queued.
- disparity_out/cost_out hold their values between results.
- Arithmetic: all values are unsigned. rowsad fits in 9 bits; acc and best_cost are COST_W bits. Overflow is impossible by construction.

## Timing
- Reset values: ready_out=1, valid_out=0, disparity_out=0, cost_out=0. State is IDLE; snapshot, acc and best are zero.
- Reset asserted mid-RUN aborts immediately: no valid_out, outputs return to reset values.
- valid_in sampled high in cycle 0 (IDLE) means:
  - RUN occupies cycles 1..6·(MAX_DISP+1) = 1..66.
  - valid_out is high in cycle 67 only.
- ready_out falls in cycle 1 and is high again in cycle 67. A valid_in in cycle 67 is accepted, giving back-to-back throughput of one result per 67 cycles.
- ready_out is decoded combinationally from state. All other outputs are registered.

## Structure
- Shared package stereo_pkg holds:
  - BLOCK_SIZE, PIX_W, PIX_PER_WORD, WORDS_PER_ROW=40
  - the state enum typedef (IDLE, RUN)
  - a pixel-extract function
- The fetcher uses the same package constants.
- Sub-module sad_row: combinational. Inputs are two 16-pixel windows plus disparity d; output is the 9-bit row SAD. It is instantiated once and fed the snapshot row selected by r.

## Test plan
- Identical left/right images with random pixels → valid_out in cycle 67, disparity_out=0, cost_out=0.
- Right pixel[k+3] = left pixel[k] on all rows, all other pixels differing → disparity_out=3, cost_out=0.
- Left all 63, right all 0 → every cost is 2268; disparity_out=0 (tie), cost_out=2268.
- Unique exact match only at d=10, which uses front pixels 10..15 → disparity_out=10, cost_out=0. Separately, change the input buffers during RUN → result unchanged.
- valid_in pulsed again in cycles 5 and 40 → ignored, exactly one valid_out (cycle 67). A second valid_in in cycle 67 → next valid_out in cycle 134.
- rst_in low for 2 cycles at cycle 30 → no valid_out, outputs zero, ready_out=1. A following request completes normally with a 67-cycle latency.
